// File: rtl/branch_addr_sequencer_pkg.sv
// Shared definitions for the branch-address sequencer and its arbiter.
//   - State encoding of the sequencer FSM (2-bit, legacy-compatible constants).
//   - Redirect source indices, also used as the bit positions of ack/req vectors.
package branch_addr_sequencer_pkg;

  typedef logic [1:0] src_idx_t;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOAD     = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam logic [1:0] REDIRECT = 2'd3;

  localparam src_idx_t SRC_EXC = 2'd0;
  localparam src_idx_t SRC_BR  = 2'd1;
  localparam src_idx_t SRC_RET = 2'd2;

endpackage

// File: rtl/branch_addr_sequencer_if.sv
// Redirect bus between the EX/exception logic, the branch-address sequencer
// and the fetch-stage PC mux.
//   Requests   : exc/br/ret valid + address (requester -> sequencer)
//   Grant      : ack[2:0] one-cycle pulse (bit0 exc, bit1 br, bit2 ret)
//   Register   : reg_d, reg_ce, reg_cs controls and redirect_addr (register Q)
//   Fetch      : flush, redirect_valid / fetch_ready handshake
//   Status     : misalign (sticky), busy
// modport master = sequencer side, modport slave = surrounding pipeline side.
interface branch_addr_sequencer_if #(
  parameter int NrOfBits = 32
);
  logic                exc_valid;
  logic [NrOfBits-1:0] exc_addr;
  logic                br_valid;
  logic [NrOfBits-1:0] br_addr;
  logic                ret_valid;
  logic [NrOfBits-1:0] ret_addr;
  logic [2:0]          ack;
  logic [NrOfBits-1:0] reg_d;
  logic                reg_ce;
  logic                reg_cs;
  logic [NrOfBits-1:0] redirect_addr;
  logic                flush;
  logic                redirect_valid;
  logic                fetch_ready;
  logic                misalign;
  logic                busy;

  modport master (
    input  exc_valid, exc_addr, br_valid, br_addr, ret_valid, ret_addr, fetch_ready,
    output ack, reg_d, reg_ce, reg_cs, redirect_addr, flush, redirect_valid, misalign, busy
  );

  modport slave (
    output exc_valid, exc_addr, br_valid, br_addr, ret_valid, ret_addr, fetch_ready,
    input  ack, reg_d, reg_ce, reg_cs, redirect_addr, flush, redirect_valid, misalign, busy
  );
endinterface

// File: rtl/branch_addr_sequencer_fixed_prio_arb3.sv
// fixed_prio_arb3: combinational 3-way fixed-priority arbiter (req[0] highest).
//   req[2:0]   in  request vector
//   grant[2:0] out one-hot grant (zero when no request)
//   grant_idx  out encoded index of the granted request (0 when none)
//   grant_any  out at least one request present
module fixed_prio_arb3
  import branch_addr_sequencer_pkg::*;
(
  input  logic [2:0] req,
  output logic [2:0] grant,
  output src_idx_t   grant_idx,
  output logic       grant_any
);

  always_comb begin
    grant     = 3'b000;
    grant_idx = SRC_EXC;
    if (req[0]) begin
      grant     = 3'b001;
      grant_idx = SRC_EXC;
    end else if (req[1]) begin
      grant     = 3'b010;
      grant_idx = SRC_BR;
    end else if (req[2]) begin
      grant     = 3'b100;
      grant_idx = SRC_RET;
    end
  end

  assign grant_any = |req;

endmodule

// File: rtl/register_flip_flop.sv
// register_flip_flop: clock-enabled register in the Logisim component style.
//   Clock, Reset (async, active-high), Tick (global clock enable)
//   D / ClockEnable : data captured on a Tick-qualified edge when ClockEnable=1
//   pre             : synchronous preset to all ones (higher priority than load)
//   cs              : 1 deselects the register; Q then reads as zero, since the
//                     on-chip mux has no real high-Z bus to float
//   ActiveLevel     : 1 = rising-edge clocking, 0 = falling-edge clocking
module register_flip_flop #(
  parameter int NrOfBits    = 32,
  parameter int ActiveLevel = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic [NrOfBits-1:0] D,
  input  logic                ClockEnable,
  input  logic                cs,
  input  logic                pre,
  output logic [NrOfBits-1:0] Q
);

  logic [NrOfBits-1:0] q_reg;

  generate
    if (ActiveLevel != 0) begin : g_rise
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                    q_reg <= '0;
        else if (Tick && pre)         q_reg <= '1;
        else if (Tick && ClockEnable) q_reg <= D;
      end
    end else begin : g_fall
      always_ff @(negedge Clock or posedge Reset) begin
        if (Reset)                    q_reg <= '0;
        else if (Tick && pre)         q_reg <= '1;
        else if (Tick && ClockEnable) q_reg <= D;
      end
    end
  endgenerate

  assign Q = cs ? '0 : q_reg;

endmodule

// File: rtl/branch_addr_sequencer.sv
// branch_addr_sequencer: arbitrates exception / branch / return redirects into
// the branch-instruction-address register, then sequences LOAD -> FLUSH ->
// REDIRECT towards fetch.
//   Clock, Reset (async, active-high), Tick (global clock enable)
//   bus (master modport of branch_addr_sequencer_if): requests, ack, register
//   controls and Q, flush, redirect handshake, misalign, busy.
// Parameters: NrOfBits (address width), FlushCycles (1..15), AlignBits.
module branch_addr_sequencer
  import branch_addr_sequencer_pkg::*;
#(
  parameter int NrOfBits    = 32,
  parameter int FlushCycles = 2,
  parameter int AlignBits   = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  branch_addr_sequencer_if.master bus
);

  localparam logic [NrOfBits-1:0] ALIGN_MASK = {NrOfBits{1'b1}} << AlignBits;
  localparam logic [3:0]          FLUSH_LOAD = 4'(FlushCycles - 1);

  logic [1:0]          state;
  logic [3:0]          flush_cnt;
  src_idx_t            cur_src;
  logic [NrOfBits-1:0] reg_d;
  logic                misalign;

  logic [2:0]          req;
  logic [2:0]          grant;
  src_idx_t            grant_idx;
  logic                grant_any;
  logic [NrOfBits-1:0] sel_addr;
  logic                preempt_ok;
  logic                accept;
  logic                reg_ce;
  logic                reg_cs;

  assign req = {bus.ret_valid, bus.br_valid, bus.exc_valid};

  fixed_prio_arb3 u_arb (
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_addr = bus.exc_addr;
    case (grant_idx)
      SRC_BR:  sel_addr = bus.br_addr;
      SRC_RET: sel_addr = bus.ret_addr;
      default: sel_addr = bus.exc_addr;
    endcase
  end

  // An exception may cut into a non-exception sequence once the register has
  // been loaded; br/ret arriving outside IDLE simply wait.
  assign preempt_ok = (state == FLUSH || state == REDIRECT) && (cur_src != SRC_EXC) && bus.exc_valid;
  assign accept     = Tick && grant_any && (state == IDLE || preempt_ok);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      flush_cnt <= 4'd0;
      cur_src   <= SRC_EXC;
      reg_d     <= '0;
      misalign  <= 1'b0;
    end else if (Tick) begin
      if (accept) begin
        // Acceptance also wins over a REDIRECT handshake completing this cycle.
        state   <= LOAD;
        cur_src <= grant_idx;
        reg_d   <= sel_addr & ALIGN_MASK;
        if (|(sel_addr & ~ALIGN_MASK)) misalign <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
          FLUSH: begin
            if (flush_cnt == 4'd0) state <= REDIRECT;
            else                   flush_cnt <= flush_cnt - 4'd1;
          end
          REDIRECT: begin
            if (bus.fetch_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tick=0 must not load the register nor emit grants; everything else holds.
  assign reg_ce             = Tick && (state == LOAD);
  assign reg_cs             = (state != REDIRECT);
  assign bus.ack            = (accept && !Reset) ? grant : 3'b000;
  assign bus.reg_d          = reg_d;
  assign bus.reg_ce         = reg_ce;
  assign bus.reg_cs         = reg_cs;
  assign bus.flush          = (state == FLUSH);
  assign bus.redirect_valid = (state == REDIRECT);
  assign bus.misalign       = misalign;
  assign bus.busy           = (state != IDLE);

  register_flip_flop #(
    .NrOfBits    (NrOfBits),
    .ActiveLevel (1)
  ) u_bia_reg (
    .Clock       (Clock),
    .Reset       (Reset),
    .Tick        (Tick),
    .D           (reg_d),
    .ClockEnable (reg_ce),
    .cs          (reg_cs),
    .pre         (1'b0),
    .Q           (bus.redirect_addr)
  );

endmodule

// File: tb/tb_branch_addr_sequencer.sv
// Testbench for branch_addr_sequencer: table-driven single-grant vectors plus
// hand-written multi-cycle sequences, with a queue of expected redirect
// addresses filled when requests are driven and drained at each redirect.
module tb_branch_addr_sequencer;

  localparam int NB = 32;
  localparam int FC = 2;
  localparam int AB = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Tick  = 1'b1;

  branch_addr_sequencer_if #(.NrOfBits(NB)) bus ();

  branch_addr_sequencer #(
    .NrOfBits    (NB),
    .FlushCycles (FC),
    .AlignBits   (AB)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  logic [NB-1:0] sb_q[$];

  typedef struct {
    logic          ev, bv, rv;
    logic [NB-1:0] ea, ba, ra;
    logic [2:0]    ack;
    logic [NB-1:0] d;
    logic          mis;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic chka(input string name, input logic [2:0] exp);
    chk(name, {29'd0, bus.ack}, {29'd0, exp});
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic mid();
    @(negedge Clock);
  endtask

  task automatic clear_inputs();
    bus.exc_valid   = 1'b0;
    bus.br_valid    = 1'b0;
    bus.ret_valid   = 1'b0;
    bus.exc_addr    = '0;
    bus.br_addr     = '0;
    bus.ret_addr    = '0;
    bus.fetch_ready = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    Tick = 1'b1;
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic sb_pop_check(input string tag);
    logic [NB-1:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb actual=redirect required=no_redirect_expected", tag);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_reg_d"}, bus.reg_d, exp);
      chk({tag, "_q"}, bus.redirect_addr, exp);
    end
  endtask

  // Entered at the start of the LOAD cycle; returns just after the edge that
  // completes the fetch handshake (start of the following IDLE cycle).
  task automatic complete_redirect(input string tag);
    int w;
    mid();
    chkb({tag, "_load_ce"}, bus.reg_ce, 1'b1);
    chkb({tag, "_load_flush"}, bus.flush, 1'b0);
    chkb({tag, "_load_rv"}, bus.redirect_valid, 1'b0);
    chka({tag, "_load_ack"}, 3'b000);
    if (sb_q.size() > 0) chk({tag, "_load_d"}, bus.reg_d, sb_q[0]);
    for (int i = 0; i < FC; i++) begin
      next_cycle();
      mid();
      chkb({tag, "_flush"}, bus.flush, 1'b1);
      chkb({tag, "_flush_ce"}, bus.reg_ce, 1'b0);
      chkb({tag, "_flush_rv"}, bus.redirect_valid, 1'b0);
      chka({tag, "_flush_ack"}, 3'b000);
    end
    next_cycle();
    mid();
    w = 0;
    while (!bus.redirect_valid && w < 20) begin
      next_cycle();
      mid();
      w++;
    end
    chk({tag, "_latency_extra"}, 32'(w), 32'd0);
    chkb({tag, "_cs"}, bus.reg_cs, 1'b0);
    sb_pop_check(tag);
    bus.fetch_ready = 1'b1;
    next_cycle();
    bus.fetch_ready = 1'b0;
  endtask

  task automatic run_vector(input int idx);
    vec_t v;
    string tag;
    v   = vecs[idx];
    tag = $sformatf("vec%0d", idx);
    apply_reset();
    bus.exc_valid = v.ev; bus.exc_addr = v.ea;
    bus.br_valid  = v.bv; bus.br_addr  = v.ba;
    bus.ret_valid = v.rv; bus.ret_addr = v.ra;
    sb_q.push_back(v.d);
    mid();
    chka({tag, "_ack"}, v.ack);
    chkb({tag, "_idle_busy"}, bus.busy, 1'b0);
    next_cycle();
    clear_inputs();
    complete_redirect(tag);
    mid();
    chkb({tag, "_done_busy"}, bus.busy, 1'b0);
    chkb({tag, "_done_cs"}, bus.reg_cs, 1'b1);
    chkb({tag, "_misalign"}, bus.misalign, v.mis);
    chka({tag, "_done_ack"}, 3'b000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_1234, 32'h0,         3'b010, 32'h0000_1234, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_2000, 32'h0000_3000, 3'b001, 32'h0000_0080, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_5678, 32'h0000_9ABC, 3'b010, 32'h0000_5678, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,         32'hDEAD_BEE0, 3'b100, 32'hDEAD_BEE0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_1237, 32'h0,         3'b010, 32'h0000_1234, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         3'b001, 32'hFFFF_FFFC, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,         32'h0000_0102, 3'b100, 32'h0000_0100, 1'b1};

    // Reset values while Reset is held, even with a request pending.
    clear_inputs();
    bus.br_valid = 1'b1;
    bus.br_addr  = 32'h0000_1234;
    mid();
    chka("rst_ack", 3'b000);
    chk("rst_reg_d", bus.reg_d, 32'h0);
    chkb("rst_ce", bus.reg_ce, 1'b0);
    chkb("rst_cs", bus.reg_cs, 1'b1);
    chkb("rst_flush", bus.flush, 1'b0);
    chkb("rst_rv", bus.redirect_valid, 1'b0);
    chkb("rst_mis", bus.misalign, 1'b0);
    chkb("rst_busy", bus.busy, 1'b0);

    for (int i = 0; i < 7; i++) run_vector(i);

    // Reset asserted in the middle of FLUSH.
    apply_reset();
    bus.br_valid = 1'b1; bus.br_addr = 32'h0000_1237;
    sb_q.push_back(32'h0000_1234);
    mid();
    chka("rmid_ack", 3'b010);
    next_cycle(); clear_inputs();
    next_cycle();
    mid();
    chkb("rmid_in_flush", bus.flush, 1'b1);
    chkb("rmid_mis_set", bus.misalign, 1'b1);
    #1 Reset = 1'b1;
    #1;
    chkb("rmid_flush", bus.flush, 1'b0);
    chkb("rmid_busy", bus.busy, 1'b0);
    chkb("rmid_cs", bus.reg_cs, 1'b1);
    chkb("rmid_rv", bus.redirect_valid, 1'b0);
    chkb("rmid_mis", bus.misalign, 1'b0);
    chk("rmid_reg_d", bus.reg_d, 32'h0);
    chka("rmid_ack0", 3'b000);
    sb_q.delete();
    next_cycle();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chkb("rmid_post_busy", bus.busy, 1'b0);
      chka("rmid_post_ack", 3'b000);
      next_cycle();
    end

    // Priority: exc, then br, then ret, each only after the previous redirect.
    apply_reset();
    bus.exc_valid = 1'b1; bus.exc_addr = 32'h0000_0080;
    bus.br_valid  = 1'b1; bus.br_addr  = 32'h0000_2000;
    bus.ret_valid = 1'b1; bus.ret_addr = 32'h0000_3000;
    sb_q.push_back(32'h0000_0080);
    sb_q.push_back(32'h0000_2000);
    sb_q.push_back(32'h0000_3000);
    mid();
    chka("prio_exc_ack", 3'b001);
    next_cycle(); bus.exc_valid = 1'b0;
    complete_redirect("prio_exc");
    mid();
    chka("prio_br_ack", 3'b010);
    next_cycle(); bus.br_valid = 1'b0;
    complete_redirect("prio_br");
    mid();
    chka("prio_ret_ack", 3'b100);
    next_cycle(); bus.ret_valid = 1'b0;
    complete_redirect("prio_ret");
    mid();
    chka("prio_end_ack", 3'b000);
    chkb("prio_end_busy", bus.busy, 1'b0);

    // Exception preempts a branch sequence in FLUSH with counter=1.
    apply_reset();
    bus.br_valid = 1'b1; bus.br_addr = 32'h0000_1234;
    sb_q.push_back(32'h0000_1234);
    mid();
    chka("pre_br_ack", 3'b010);
    next_cycle(); bus.br_valid = 1'b0;
    next_cycle();
    bus.exc_valid = 1'b1; bus.exc_addr = 32'h0000_0100;
    void'(sb_q.pop_back());
    sb_q.push_back(32'h0000_0100);
    mid();
    chkb("pre_in_flush", bus.flush, 1'b1);
    chka("pre_exc_ack", 3'b001);
    next_cycle(); bus.exc_valid = 1'b0;
    complete_redirect("pre");
    mid();
    chka("pre_no_reack", 3'b000);
    chkb("pre_busy", bus.busy, 1'b0);

    // Tick gating: no grant with Tick=0, LOAD held for 5 gated cycles.
    apply_reset();
    Tick = 1'b0;
    bus.br_valid = 1'b1; bus.br_addr = 32'h0000_4444;
    mid();
    chka("tick_idle_ack", 3'b000);
    next_cycle();
    Tick = 1'b1;
    sb_q.push_back(32'h0000_4444);
    mid();
    chka("tick_ack", 3'b010);
    next_cycle(); bus.br_valid = 1'b0;
    Tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chkb("tick_hold_ce", bus.reg_ce, 1'b0);
      chkb("tick_hold_busy", bus.busy, 1'b1);
      chkb("tick_hold_flush", bus.flush, 1'b0);
      next_cycle();
    end
    Tick = 1'b1;
    complete_redirect("tick");

    // Handshake completing together with an exception: exception wins.
    apply_reset();
    bus.br_valid = 1'b1; bus.br_addr = 32'h0000_5000;
    sb_q.push_back(32'h0000_5000);
    mid();
    chka("hs_br_ack", 3'b010);
    next_cycle(); bus.br_valid = 1'b0;
    for (int i = 0; i < 1 + FC; i++) next_cycle();
    mid();
    chkb("hs_rv", bus.redirect_valid, 1'b1);
    sb_pop_check("hs_br");
    bus.fetch_ready = 1'b1;
    bus.exc_valid   = 1'b1; bus.exc_addr = 32'h0000_0200;
    sb_q.push_back(32'h0000_0200);
    #1;
    chka("hs_exc_ack", 3'b001);
    next_cycle();
    bus.fetch_ready = 1'b0; bus.exc_valid = 1'b0;
    complete_redirect("hs_exc");

    // Misalign stays set through later aligned redirects until Reset.
    apply_reset();
    bus.br_valid = 1'b1; bus.br_addr = 32'h0000_1237;
    sb_q.push_back(32'h0000_1234);
    mid();
    chka("mis_ack1", 3'b010);
    next_cycle(); bus.br_valid = 1'b0;
    complete_redirect("mis1");
    bus.br_valid = 1'b1; bus.br_addr = 32'h0000_2000;
    sb_q.push_back(32'h0000_2000);
    mid();
    chka("mis_ack2", 3'b010);
    next_cycle(); bus.br_valid = 1'b0;
    complete_redirect("mis2");
    mid();
    chkb("mis_sticky", bus.misalign, 1'b1);
    apply_reset();
    mid();
    chkb("mis_cleared", bus.misalign, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
